alarm_sequencer: RTL

- Controls alarm sounding for the alarm clock datapath.
- Compares the running time from the counter with the stored alarm time from the alarm register.
- Sequences the RINGING, SNOOZE and timeout behaviour and drives the alarm sound line to the display/sound path.
- Sits between counter/alarm_reg/aclk_timegen and the LCD driver's sound input.

---
 rtl/aclk_defs_pkg.sv | 19 +
 rtl/aclk_edge_det.sv | 27 ++
 rtl/alarm_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/aclk_defs_pkg.sv
// aclk_defs: shared definitions for the alarm clock datapath.
//   - alarm_state_t : sequencer state encoding (IDLE=0, ARMED=1, RINGING=2, SNOOZE=3)
//   - DIGIT_W       : BCD digit width
//   - *_DEF         : default SNOOZE_MIN / MAX_SNOOZE / RING_SECS values
package aclk_defs;

    localparam int DIGIT_W        = 4;
    localparam int SNOOZE_MIN_DEF = 5;
    localparam int MAX_SNOOZE_DEF = 3;
    localparam int RING_SECS_DEF  = 60;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } alarm_state_t;

endpackage

// File: rtl/aclk_edge_det.sv
// aclk_edge_det: rising-edge detector for a synchronous level input.
// Ports:
//   clock  - system clock
//   reset  - asynchronous, active-low reset (history register loads RST_VAL)
//   level  - synchronous level input
//   press  - one-cycle pulse on a 0->1 transition of level
// Resetting the history to 1 means a button already held at reset
// release does not produce a press.
module aclk_edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic press
);

    logic level_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) level_q <= RST_VAL;
        else        level_q <= level;
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: compares current and alarm time, sequences
// ARMED/RINGING/SNOOZE with ring timeout and drives the alarm sound line.
// Ports:
//   clock, reset (async active-low)
//   alarm_enable            - alarm armed while high
//   snooze_button, stop_button - synchronous levels, edge-detected here
//   one_second, one_minute  - single-cycle timing pulses
//   current_time_*, alarm_time_* - BCD HH:MM digits
//   alarm_sound   - sound drive
//   alarm_state   - current state (IDLE=0, ARMED=1, RINGING=2, SNOOZE=3)
//   snooze_count  - snoozes used in the current alarm event
//   alarm_missed  - sticky, set on ring timeout
// Build option: define ALARM_BEEP_PATTERN_EN for a 1 s on / 1 s off beep
// while ringing; otherwise alarm_sound is a steady level in RINGING.
module alarm_sequencer
    import aclk_defs::*;
#(
    parameter int SNOOZE_MIN = SNOOZE_MIN_DEF,
    parameter int MAX_SNOOZE = MAX_SNOOZE_DEF,
    parameter int RING_SECS  = RING_SECS_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               alarm_enable,
    input  logic               snooze_button,
    input  logic               stop_button,
    input  logic               one_second,
    input  logic               one_minute,
    input  logic [DIGIT_W-1:0] current_time_ms_hr,
    input  logic [DIGIT_W-1:0] current_time_ls_hr,
    input  logic [DIGIT_W-1:0] current_time_ms_min,
    input  logic [DIGIT_W-1:0] current_time_ls_min,
    input  logic [DIGIT_W-1:0] alarm_time_ms_hr,
    input  logic [DIGIT_W-1:0] alarm_time_ls_hr,
    input  logic [DIGIT_W-1:0] alarm_time_ms_min,
    input  logic [DIGIT_W-1:0] alarm_time_ls_min,
    output logic               alarm_sound,
    output logic [1:0]         alarm_state,
    output logic [2:0]         snooze_count,
    output logic               alarm_missed
);

    localparam logic [7:0] RING_LAST   = 8'(RING_SECS - 1);
    localparam logic [3:0] SNOOZE_LAST = 4'(SNOOZE_MIN - 1);
    localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

    alarm_state_t state, state_nxt;
    logic [7:0]   ring_cnt, ring_nxt;
    logic [3:0]   min_cnt, min_nxt;
    logic [2:0]   sc_nxt;
    logic         missed_nxt;
    logic         match, match_q, match_rise;
    logic         snooze_press, stop_press;

    aclk_edge_det #(.RST_VAL(1'b1)) u_snooze_edge (
        .clock (clock),
        .reset (reset),
        .level (snooze_button),
        .press (snooze_press)
    );

    aclk_edge_det #(.RST_VAL(1'b1)) u_stop_edge (
        .clock (clock),
        .reset (reset),
        .level (stop_button),
        .press (stop_press)
    );

    assign match = (current_time_ms_hr  == alarm_time_ms_hr)  &&
                   (current_time_ls_hr  == alarm_time_ls_hr)  &&
                   (current_time_ms_min == alarm_time_ms_min) &&
                   (current_time_ls_min == alarm_time_ls_min);

    assign match_rise = match & ~match_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            ring_cnt     <= '0;
            min_cnt      <= '0;
            snooze_count <= '0;
            alarm_missed <= 1'b0;
            match_q      <= 1'b1;   // a match present at reset release never fires
        end else begin
            state        <= state_nxt;
            ring_cnt     <= ring_nxt;
            min_cnt      <= min_nxt;
            snooze_count <= sc_nxt;
            alarm_missed <= missed_nxt;
            match_q      <= match;
        end
    end

    // Priority: enable low > stop > snooze > timeout > match edge.
    // Timing pulses coinciding with a transition are not counted.
    always_comb begin
        state_nxt  = state;
        ring_nxt   = ring_cnt;
        min_nxt    = min_cnt;
        sc_nxt     = snooze_count;
        missed_nxt = alarm_missed;
        if (!alarm_enable) begin
            state_nxt = ST_IDLE;
            ring_nxt  = '0;
            min_nxt   = '0;
            sc_nxt    = '0;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_ARMED;
                ST_ARMED: begin
                    if (match_rise) begin
                        state_nxt = ST_RINGING;
                        ring_nxt  = '0;
                        sc_nxt    = '0;
                    end
                end
                ST_RINGING: begin
                    if (stop_press || (snooze_press && snooze_count >= SNOOZE_MAX)) begin
                        state_nxt  = ST_ARMED;
                        sc_nxt     = '0;
                        missed_nxt = 1'b0;
                        ring_nxt   = '0;
                    end else if (snooze_press) begin
                        state_nxt = ST_SNOOZE;
                        sc_nxt    = snooze_count + 3'd1;
                        min_nxt   = '0;
                        ring_nxt  = '0;
                    end else if (one_second) begin
                        if (ring_cnt == RING_LAST) begin
                            state_nxt  = ST_ARMED;
                            missed_nxt = 1'b1;
                            sc_nxt     = '0;
                            ring_nxt   = '0;
                        end else begin
                            ring_nxt = ring_cnt + 8'd1;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (stop_press) begin
                        state_nxt = ST_ARMED;
                        sc_nxt    = '0;
                        min_nxt   = '0;
                    end else if (one_minute) begin
                        if (min_cnt == SNOOZE_LAST) begin
                            state_nxt = ST_RINGING;
                            ring_nxt  = '0;
                            min_nxt   = '0;
                        end else begin
                            min_nxt = min_cnt + 4'd1;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign alarm_state = state;

`ifdef ALARM_BEEP_PATTERN_EN
    logic beep_q, beep_nxt;

    // High on entry to RINGING, toggles on each one_second while ringing.
    always_comb begin
        beep_nxt = 1'b0;
        if (state_nxt == ST_RINGING) begin
            if (state != ST_RINGING) beep_nxt = 1'b1;
            else if (one_second)     beep_nxt = ~beep_q;
            else                     beep_nxt = beep_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) beep_q <= 1'b0;
        else        beep_q <= beep_nxt;
    end

    assign alarm_sound = beep_q;
`else
    assign alarm_sound = (state == ST_RINGING);
`endif

endmodule
